// File: rtl/compressed_line_fetcher_pkg.sv
// rtl/compressed_line_fetcher_pkg.sv - shared encodings, size table and FSM type for the line fetcher
package compressed_line_fetcher_pkg;

  localparam int LINE_BITS = 256;

  localparam logic [3:0] ENC_ZERO  = 4'd0;
  localparam logic [3:0] ENC_B96_A = 4'd2;
  localparam logic [3:0] ENC_B128  = 4'd3;
  localparam logic [3:0] ENC_B192  = 4'd4;
  localparam logic [3:0] ENC_B96_B = 4'd5;
  localparam logic [3:0] ENC_B160  = 4'd6;
  localparam logic [3:0] ENC_B144  = 4'd7;
  localparam logic [3:0] ENC_RAW   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_t;

  // Table of record for stored line size; the decompressor decodes with the same function.
  function automatic logic [8:0] enc_to_size(input logic [3:0] enc);
    case (enc)
      ENC_ZERO:  return 9'd1;
      ENC_B96_A: return 9'd96;
      ENC_B128:  return 9'd128;
      ENC_B192:  return 9'd192;
      ENC_B96_B: return 9'd96;
      ENC_B160:  return 9'd160;
      ENC_B144:  return 9'd144;
      default:   return 9'(LINE_BITS);
    endcase
  endfunction

endpackage

// File: rtl/compressed_line_fetcher_if.sv
// rtl/compressed_line_fetcher_if.sv - request, memory and decompressor handshakes of the line fetcher
interface compressed_line_fetcher_if
  import compressed_line_fetcher_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 32
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic [3:0]           req_encoding;
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [ADDR_W-1:0]    mem_req_addr;
  logic                 mem_rsp_valid;
  logic [BEAT_W-1:0]    mem_rsp_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LINE_BITS-1:0] out_data;
  logic [3:0]           out_encoding;
  logic [8:0]           out_size;

  modport master (
    output req_valid, req_addr, req_encoding, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
    input  req_ready, mem_req_valid, mem_req_addr, out_valid, out_data, out_encoding, out_size
  );

  modport slave (
    input  req_valid, req_addr, req_encoding, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
    output req_ready, mem_req_valid, mem_req_addr, out_valid, out_data, out_encoding, out_size
  );

endinterface

// File: rtl/compressed_line_fetcher_line_assembly_buffer.sv
// rtl/compressed_line_fetcher_line_assembly_buffer.sv - 256-bit line register written one beat slot at a time
module compressed_line_fetcher_line_assembly_buffer
  import compressed_line_fetcher_pkg::*;
#(
  parameter int BEAT_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic [BEAT_W-1:0]    i_wr_data,
  output logic [LINE_BITS-1:0] o_line
);

  logic [LINE_BITS-1:0] r_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line <= '0;
    end else if (i_clear) begin
      r_line <= '0;
    end else if (i_wr_en) begin
      r_line[int'(i_wr_idx) * BEAT_W +: BEAT_W] <= i_wr_data;
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/compressed_line_fetcher.sv
// rtl/compressed_line_fetcher.sv - fetches a compressed cache line beat by beat and hands it to the decompressor
module compressed_line_fetcher
  import compressed_line_fetcher_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int BEAT_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  compressed_line_fetcher_if.slave bus,
  output logic                     o_protocol_err
);

  localparam int                SLOTS  = LINE_BITS / BEAT_W;
  localparam int                CNT_W  = $clog2(SLOTS + 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BEAT_W / 8);

  fetch_state_t         r_state;
  fetch_state_t         w_next_state;
  logic [ADDR_W-1:0]    r_addr;
  logic [3:0]           r_enc;
  logic [8:0]           r_size;
  logic [CNT_W-1:0]     r_issued;
  logic [CNT_W-1:0]     r_received;
  logic [CNT_W-1:0]     w_beats;
  logic [CNT_W-1:0]     w_outstanding;
  logic                 r_protocol_err;
  logic                 w_req_fire;
  logic                 w_in_fetch;
  logic                 w_mem_valid;
  logic                 w_mem_fire;
  logic                 w_rsp_take;
  logic                 w_rsp_stray;
  logic                 w_last_beat;
  logic [LINE_BITS-1:0] w_line;

  assign w_beats       = CNT_W'((32'(r_size) + 32'(BEAT_W - 1)) / 32'(BEAT_W));
  assign w_outstanding = r_issued - r_received;
  assign w_in_fetch    = (r_state == ST_FETCH);
  assign w_req_fire    = bus.req_valid && bus.req_ready;
  assign w_mem_valid   = w_in_fetch && (r_issued < w_beats)
                         && (32'(w_outstanding) < 32'(MAX_OUTSTANDING));
  assign w_mem_fire    = w_mem_valid && bus.mem_req_ready;
  // A response with nothing outstanding (or outside FETCH) has no slot to land in.
  assign w_rsp_take    = w_in_fetch && bus.mem_rsp_valid && (r_received != r_issued);
  assign w_rsp_stray   = bus.mem_rsp_valid && !w_rsp_take;
  assign w_last_beat   = w_rsp_take && ((r_received + CNT_W'(1)) == w_beats);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_enc          <= '0;
      r_size         <= '0;
      r_issued       <= '0;
      r_received     <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_req_fire) begin
        r_addr     <= bus.req_addr;
        r_enc      <= bus.req_encoding;
        r_size     <= enc_to_size(bus.req_encoding);
        r_issued   <= '0;
        r_received <= '0;
      end else begin
        if (w_mem_fire) r_issued <= r_issued + CNT_W'(1);
        if (w_rsp_take) r_received <= r_received + CNT_W'(1);
      end
      if (w_rsp_stray) r_protocol_err <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_req_fire) w_next_state = ST_FETCH;
      ST_FETCH: if (w_last_beat) w_next_state = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  compressed_line_fetcher_line_assembly_buffer #(
    .BEAT_W (BEAT_W),
    .IDX_W  (CNT_W)
  ) u_line_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_req_fire),
    .i_wr_en   (w_rsp_take),
    .i_wr_idx  (r_received),
    .i_wr_data (bus.mem_rsp_data),
    .o_line    (w_line)
  );

  // Ready is masked while reset is held so no request is taken before release.
  assign bus.req_ready     = (r_state == ST_IDLE) && i_rst_n;
  assign bus.mem_req_valid = w_mem_valid;
  assign bus.mem_req_addr  = r_addr + ADDR_W'(r_issued) * STRIDE;
  assign bus.out_valid     = (r_state == ST_DONE);
  assign bus.out_data      = w_line;
  assign bus.out_encoding  = r_enc;
  assign bus.out_size      = r_size;
  assign o_protocol_err    = r_protocol_err;

endmodule
